instr_mem_loader: RTL and testbench
===================================

# instr_mem_loader

Boot-time program loader that writes the instruction memory of the single-cycle core. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Each completed word is written to consecutive word addresses starting at 0, and the core is held in reset until loading finishes. It drives the instruction memory's write port; the core's fetch path reads the same memory.

## Interface
- DEPTH, 16, number of 32-bit instruction words in the target memory
- ADDR_W, 4, word-address width; DEPTH ≤ 2^ADDR_W
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a load; ignored unless in IDLE or DONE
- byte_valid  input  1  byte_data is valid this cycle
- byte_data  input  8  program byte, little-endian within each word
- byte_last  input  1  qualifies byte_valid; marks the final byte of the program
- byte_ready  output  1  loader accepts a byte this cycle
- wr_en  output  1  instruction-memory write strobe, one cycle per word
- wr_addr  output  ADDR_W  word address of the write
- wr_data  output  32  assembled instruction word
- busy  output  1  load in progress
- done  output  1  load complete
- cpu_hold  output  1  holds the core in reset; equals busy
- word_count  output  ADDR_W+1  number of words written in the current or last load
- checksum  output  32  XOR of all written words (see Configuration)

## Operation
- States:
  - IDLE: byte_ready=0, busy=0, done=0.
  - LOAD: byte_ready=1, busy=1.
  - WRITE: byte_ready=0, wr_en=1, busy=1.
  - DONE: done=1, busy=0.
- IDLE or DONE, start=1 → LOAD. On entry, clear byte index, word address, word_count, assembly register and checksum.
- LOAD, handshake (byte_valid & byte_ready):
  - byte k (k=0..3) is stored into assembly bits [8k+7:8k]; the byte index increments.
  - After byte 3 is accepted, or after any byte with byte_last=1, → WRITE.
  - Unfilled upper bytes of a short final word are 0.
- WRITE: wr_en=1, wr_addr = current word address, wr_data = assembly register.
  - At the end of the cycle: word address +1, word_count +1, byte index and assembly register cleared.
  - → DONE if the word just written carried byte_last, or if the word address was DEPTH-1 (memory full).
  - Otherwise → LOAD.
- Memory full: bytes arriving after the DEPTH-th word are not accepted (byte_ready=0 in DONE).
- byte_last on byte 3 produces a normal full-word write, then DONE.
- start asserted in LOAD or WRITE is ignored.
- start in DONE begins a new load from address 0.
- byte_valid=0 in LOAD: hold all state indefinitely; no timeout.
- wr_en, wr_addr and wr_data are decoded from registered state and registers only; no combinational path from byte inputs.

## Timing
- Reset values:
  - state IDLE
  - byte_ready=0, wr_en=0, wr_addr=0, wr_data=0
  - busy=0, done=0, cpu_hold=0
  - word_count=0, checksum=0
- rst mid-load: next cycle is IDLE with all outputs at reset values. The partial word is discarded; words already written are not undone.
- start sampled at cycle N → LOAD and byte_ready=1 at N+1.
- 4th byte accepted at cycle N → wr_en=1 at N+1 → byte_ready=1 again at N+2. Throughput is one word per 5 cycles with a continuous stream.
- Final write at cycle M → done=1, cpu_hold=0 at M+1.
- word_count and checksum update on the clock edge ending the WRITE cycle.

## Configuration
- LOADER_CHECKSUM_EN defined: checksum register XORs in wr_data at every WRITE cycle; it is cleared on start and on rst.
- LOADER_CHECKSUM_EN undefined: no checksum register; checksum tied to 32'h0.
- No other behaviour differs between the two builds.

## Test plan
- rst, start, bytes 13 00 70 00 (last on 00) → one wr_en at wr_addr=0 with wr_data=0x00700013, then done=1, word_count=1.
- Two words 13 00 70 00, 93 01 A0 0B (last on 0B) → writes 0x00700013 @0 and 0x0BA00193 @1. checksum=0x0BD00180 with LOADER_CHECKSUM_EN; 0 without.
- Bytes AA BB with byte_last on BB → wr_data=0x0000BBAA @0, then done=1.
- 16 full words streamed with no byte_last, plus extra valid bytes → 16 writes @0..15, done=1 after the 16th, byte_ready=0 and no 17th write.
- rst asserted after 2 bytes of word 3 → next cycle IDLE, wr_en=0, busy=0, word_count=0; subsequent start reloads from address 0.
- start held high during LOAD, and byte_valid toggled with gaps → no restart, word assembly unaffected by gaps, wr_en exactly one cycle per word.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Boot-time loader: assembles a little-endian byte stream into 32-bit words and
// writes them to instruction memory from address 0. Optional macro: LOADER_CHECKSUM_EN.
module instr_mem_loader #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_byte_valid,
  input  logic [7:0]        i_byte_data,
  input  logic              i_byte_last,
  output logic              o_byte_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [31:0]       o_wr_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_cpu_hold,
  output logic [ADDR_W:0]   o_word_count,
  output logic [31:0]       o_checksum
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  logic [1:0]        r_byteIdx;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_wordCount;
  logic [31:0]       r_asm;
  logic              r_lastSeen;

  logic w_startOk;
  logic w_wordEnd;

  assign w_startOk = i_start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_wordEnd = (r_byteIdx == 2'd3) || i_byte_last;

  // Main sequencer: a word is flushed after four bytes or early on byte_last,
  // and the load ends on byte_last or when the last memory word is written.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_byteIdx   <= 2'd0;
      r_addr      <= '0;
      r_wordCount <= '0;
      r_asm       <= 32'h0;
      r_lastSeen  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_startOk) begin
            r_state     <= S_LOAD;
            r_byteIdx   <= 2'd0;
            r_addr      <= '0;
            r_wordCount <= '0;
            r_asm       <= 32'h0;
            r_lastSeen  <= 1'b0;
          end
        end
        S_LOAD: begin
          if (i_byte_valid) begin
            case (r_byteIdx)
              2'd0:    r_asm[7:0]   <= i_byte_data;
              2'd1:    r_asm[15:8]  <= i_byte_data;
              2'd2:    r_asm[23:16] <= i_byte_data;
              default: r_asm[31:24] <= i_byte_data;
            endcase
            r_byteIdx <= r_byteIdx + 2'd1;
            if (w_wordEnd) begin
              r_state    <= S_WRITE;
              r_lastSeen <= i_byte_last;
            end
          end
        end
        S_WRITE: begin
          r_addr      <= r_addr + 1'b1;
          r_wordCount <= r_wordCount + 1'b1;
          r_byteIdx   <= 2'd0;
          r_asm       <= 32'h0;
          r_lastSeen  <= 1'b0;
          if (r_lastSeen || r_addr == LAST_ADDR) begin
            r_state <= S_DONE;
          end else begin
            r_state <= S_LOAD;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] r_checksum;

  // Running XOR of every word written during the current load.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_startOk) begin
      r_checksum <= 32'h0;
    end else if (r_state == S_WRITE) begin
      r_checksum <= r_checksum ^ r_asm;
    end
  end

  assign o_checksum = r_checksum;
`else
  assign o_checksum = 32'h0;
`endif

  // Outputs depend only on registered state, never on the byte inputs.
  assign o_byte_ready = (r_state == S_LOAD);
  assign o_wr_en      = (r_state == S_WRITE);
  assign o_wr_addr    = r_addr;
  assign o_wr_data    = r_asm;
  assign o_busy       = (r_state == S_LOAD) || (r_state == S_WRITE);
  assign o_done       = (r_state == S_DONE);
  assign o_cpu_hold   = o_busy;
  assign o_word_count = r_wordCount;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: expected writes are queued by the
// stimulus and popped by a monitor whenever the loader strobes its write port.
module tb_instr_mem_loader;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic              i_clk;
  logic              i_rst;
  logic              i_start;
  logic              i_byte_valid;
  logic [7:0]        i_byte_data;
  logic              i_byte_last;
  logic              o_byte_ready;
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [31:0]       o_wr_data;
  logic              o_busy;
  logic              o_done;
  logic              o_cpu_hold;
  logic [ADDR_W:0]   o_word_count;
  logic [31:0]       o_checksum;

  int  passCount;
  int  checkCount;
  wr_t expQ[$];

  instr_mem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_byte_valid (i_byte_valid),
    .i_byte_data  (i_byte_data),
    .i_byte_last  (i_byte_last),
    .o_byte_ready (o_byte_ready),
    .o_wr_en      (o_wr_en),
    .o_wr_addr    (o_wr_addr),
    .o_wr_data    (o_wr_data),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_cpu_hold   (o_cpu_hold),
    .o_word_count (o_word_count),
    .o_checksum   (o_checksum)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Expected checksum depends on which build of the loader is under test.
  function automatic logic [31:0] expCk(input logic [31:0] x);
`ifdef LOADER_CHECKSUM_EN
    return x;
`else
    return 32'h0 & x;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Monitor: every write strobe must match the oldest queued expectation.
  always @(negedge i_clk) begin
    if (o_wr_en === 1'b1) begin
      if (expQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpected_write: got addr %0h data %0h, expected no write", o_wr_addr, o_wr_data);
      end else begin
        wr_t e;
        e = expQ.pop_front();
        checkOutput("wr_addr", 32'(o_wr_addr), 32'(e.addr));
        checkOutput("wr_data", o_wr_data, e.data);
      end
    end
  end

  task automatic startLoad();
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
  endtask

  // Offers one byte after `gap` idle cycles and holds it until accepted.
  task automatic applyStimulus(input logic [7:0] data, input logic last, input int gap);
    logic accepted;
    int   cycles;
    for (int g = 0; g < gap; g++) begin
      @(posedge i_clk); #1;
    end
    i_byte_valid = 1'b1;
    i_byte_data  = data;
    i_byte_last  = last;
    accepted = 1'b0;
    cycles   = 0;
    while (!accepted && cycles < 20) begin
      accepted = o_byte_ready;
      @(posedge i_clk); #1;
      cycles++;
    end
    if (!accepted) begin
      checkCount++;
      $display("[TB] FAIL byte_accept_timeout: got ready=0 for 20 cycles, expected acceptance of %0h", data);
    end
    i_byte_valid = 1'b0;
    i_byte_last  = 1'b0;
  endtask

  task automatic sendWord(input logic [ADDR_W-1:0] addr, input logic [31:0] w, input logic last);
    wr_t e;
    e.addr = addr;
    e.data = w;
    expQ.push_back(e);
    applyStimulus(w[7:0],   1'b0, 0);
    applyStimulus(w[15:8],  1'b0, 0);
    applyStimulus(w[23:16], 1'b0, 0);
    applyStimulus(w[31:24], last, 0);
  endtask

  task automatic waitDone(input string name);
    int cycles;
    cycles = 0;
    while (o_done !== 1'b1 && cycles < 50) begin
      @(posedge i_clk); #1;
      cycles++;
    end
    checkOutput(name, 32'(o_done), 32'h1);
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] ck;
    wr_t e;
    passCount    = 0;
    checkCount   = 0;
    i_rst        = 1'b1;
    i_start      = 1'b0;
    i_byte_valid = 1'b0;
    i_byte_data  = 8'h0;
    i_byte_last  = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    checkOutput("rst_byte_ready", 32'(o_byte_ready), 32'h0);
    checkOutput("rst_wr_en",      32'(o_wr_en),      32'h0);
    checkOutput("rst_wr_addr",    32'(o_wr_addr),    32'h0);
    checkOutput("rst_wr_data",    o_wr_data,         32'h0);
    checkOutput("rst_busy",       32'(o_busy),       32'h0);
    checkOutput("rst_done",       32'(o_done),       32'h0);
    checkOutput("rst_cpu_hold",   32'(o_cpu_hold),   32'h0);
    checkOutput("rst_word_count", 32'(o_word_count), 32'h0);
    checkOutput("rst_checksum",   o_checksum,        32'h0);
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    $display("[TB] single word");
    startLoad();
    checkOutput("start_ready", 32'(o_byte_ready), 32'h1);
    checkOutput("start_hold",  32'(o_cpu_hold),   32'h1);
    sendWord(4'd0, 32'h00700013, 1'b1);
    waitDone("w1_done");
    checkOutput("w1_count", 32'(o_word_count), 32'd1);
    checkOutput("w1_hold",  32'(o_cpu_hold),   32'h0);
    checkOutput("w1_ck",    o_checksum,        expCk(32'h00700013));

    $display("[TB] two words, restart from done");
    startLoad();
    sendWord(4'd0, 32'h00700013, 1'b0);
    sendWord(4'd1, 32'h0BA00193, 1'b1);
    waitDone("w2_done");
    checkOutput("w2_count", 32'(o_word_count), 32'd2);
    checkOutput("w2_ck",    o_checksum,        expCk(32'h0BD00180));

    $display("[TB] short final word");
    startLoad();
    e.addr = 4'd0;
    e.data = 32'h0000BBAA;
    expQ.push_back(e);
    applyStimulus(8'hAA, 1'b0, 0);
    applyStimulus(8'hBB, 1'b1, 0);
    waitDone("short_done");
    checkOutput("short_count", 32'(o_word_count), 32'd1);

    $display("[TB] fill memory");
    startLoad();
    ck = 32'h0;
    for (int i = 0; i < DEPTH; i++) begin
      w = {8'(16*i+3), 8'(16*i+2), 8'(16*i+1), 8'(16*i)};
      ck = ck ^ w;
      sendWord(ADDR_W'(i), w, 1'b0);
    end
    waitDone("full_done");
    checkOutput("full_count", 32'(o_word_count), 32'd16);
    checkOutput("full_ck",    o_checksum,        expCk(ck));
    i_byte_valid = 1'b1;
    i_byte_data  = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      checkOutput("full_ready", 32'(o_byte_ready), 32'h0);
      @(posedge i_clk); #1;
    end
    i_byte_valid = 1'b0;
    checkOutput("full_done_hold", 32'(o_done), 32'h1);

    $display("[TB] reset mid-load");
    startLoad();
    sendWord(4'd0, 32'h11111111, 1'b0);
    sendWord(4'd1, 32'h22222222, 1'b0);
    sendWord(4'd2, 32'h33333333, 1'b0);
    applyStimulus(8'h44, 1'b0, 0);
    applyStimulus(8'h55, 1'b0, 0);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    checkOutput("mid_wr_en", 32'(o_wr_en),      32'h0);
    checkOutput("mid_busy",  32'(o_busy),       32'h0);
    checkOutput("mid_ready", 32'(o_byte_ready), 32'h0);
    checkOutput("mid_count", 32'(o_word_count), 32'h0);
    checkOutput("mid_data",  o_wr_data,         32'h0);
    startLoad();
    sendWord(4'd0, 32'h00700013, 1'b1);
    waitDone("mid_reload_done");
    checkOutput("mid_reload_count", 32'(o_word_count), 32'd1);

    $display("[TB] start held, gapped bytes");
    i_start = 1'b1;
    @(posedge i_clk); #1;
    e.addr = 4'd0;
    e.data = 32'h44332211;
    expQ.push_back(e);
    e.addr = 4'd1;
    e.data = 32'h88776655;
    expQ.push_back(e);
    applyStimulus(8'h11, 1'b0, 2);
    applyStimulus(8'h22, 1'b0, 0);
    applyStimulus(8'h33, 1'b0, 3);
    applyStimulus(8'h44, 1'b0, 1);
    applyStimulus(8'h55, 1'b0, 2);
    applyStimulus(8'h66, 1'b0, 0);
    applyStimulus(8'h77, 1'b0, 1);
    i_start = 1'b0;
    applyStimulus(8'h88, 1'b1, 2);
    waitDone("gap_done");
    checkOutput("gap_count", 32'(o_word_count), 32'd2);
    checkOutput("gap_ck",    o_checksum,        expCk(32'h44332211 ^ 32'h88776655));

    repeat (3) @(posedge i_clk);
    #1;
    checkOutput("queue_empty", 32'(expQ.size()), 32'h0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
